// File: rtl/fnd_scan_decoder.sv
// Receive-side snooper for a 4-digit multiplexed 7-segment bus: filters scan transitions,
// decodes each stable digit pattern and publishes complete 4-digit frames.
module fnd_scan_decoder #(
    parameter bit FONT_ACT_LOW  = 1'b1,
    parameter bit DIGIT_ACT_LOW = 1'b1,
    parameter int STABLE_CYCLES = 4,
    parameter int TIMEOUT       = 1024
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [7:0]  i_font,
    input  logic [3:0]  i_digit,
    output logic [15:0] o_value,
    output logic [3:0]  o_dp,
    output logic        o_frame_valid,
    output logic        o_err,
    output logic [7:0]  o_err_cnt,
    output logic        o_stalled
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_HIT = CNT_W'(STABLE_CYCLES - 2);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0]  TO_ONE  = TO_W'(1);

    typedef enum logic [1:0] {
        S_WAIT    = 2'd0,
        S_COLLECT = 2'd1,
        S_EMIT    = 2'd2
    } state_t;

    // Returns {undecodable, code} for an active-high gfedcba pattern.
    function automatic logic [4:0] decode_seg(input logic [6:0] seg);
        logic [4:0] res;
        case (seg)
            7'h3F:   res = {1'b0, 4'h0};
            7'h06:   res = {1'b0, 4'h1};
            7'h5B:   res = {1'b0, 4'h2};
            7'h4F:   res = {1'b0, 4'h3};
            7'h66:   res = {1'b0, 4'h4};
            7'h6D:   res = {1'b0, 4'h5};
            7'h7D:   res = {1'b0, 4'h6};
            7'h07:   res = {1'b0, 4'h7};
            7'h7F:   res = {1'b0, 4'h8};
            7'h6F:   res = {1'b0, 4'h9};
            7'h00:   res = {1'b0, 4'hA};
            default: res = {1'b1, 4'hF};
        endcase
        return res;
    endfunction

    function automatic logic [1:0] digit_index(input logic [3:0] sel);
        logic [1:0] idx;
        case (sel)
            4'b0001: idx = 2'd0;
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    logic [7:0]       font_r, prev_font_r;
    logic [3:0]       digit_r, prev_digit_r;
    logic [CNT_W-1:0] stable_cnt_r;
    logic [TO_W-1:0]  timeout_cnt_r;
    logic [15:0]      shadow_r;
    logic [3:0]       shadow_dp_r;
    logic [3:0]       mask_r;
    state_t           state_r;

    logic             sel_valid_s, same_s, commit_s, full_s;
    logic [1:0]       idx_s;
    logic [4:0]       dec_s;
    logic [15:0]      shadow_nxt_s;
    logic [3:0]       shadow_dp_nxt_s, mask_nxt_s;
    logic [TO_W-1:0]  timeout_nxt_s;

    // Dwell detection, decode and next shadow/mask/timeout values.
    always_comb begin
        sel_valid_s     = (digit_r != 4'd0) && ((digit_r & (digit_r - 4'd1)) == 4'd0);
        same_s          = (font_r == prev_font_r) && (digit_r == prev_digit_r);
        commit_s        = sel_valid_s && same_s && (stable_cnt_r == CNT_HIT);
        idx_s           = digit_index(digit_r);
        dec_s           = decode_seg(font_r[6:0]);
        shadow_nxt_s    = shadow_r;
        shadow_dp_nxt_s = shadow_dp_r;
        // The emit cycle starts a fresh frame, so a commit landing there is kept.
        if (state_r == S_EMIT) begin
            mask_nxt_s = 4'd0;
        end else begin
            mask_nxt_s = mask_r;
        end
        if (commit_s) begin
            shadow_nxt_s[{idx_s, 2'b00} +: 4] = dec_s[3:0];
            shadow_dp_nxt_s[idx_s]            = font_r[7];
            mask_nxt_s                        = mask_nxt_s | (4'd1 << idx_s);
        end else begin
            mask_nxt_s = mask_nxt_s;
        end
        full_s = (mask_nxt_s == 4'hF);
        if (commit_s) begin
            timeout_nxt_s = {TO_W{1'b0}};
        end else if (timeout_cnt_r == TO_MAX) begin
            timeout_nxt_s = TO_MAX;
        end else begin
            timeout_nxt_s = timeout_cnt_r + TO_ONE;
        end
    end

    // Input sampling with polarity normalisation and the stability counter.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            font_r       <= 8'd0;
            digit_r      <= 4'd0;
            prev_font_r  <= 8'd0;
            prev_digit_r <= 4'd0;
            stable_cnt_r <= {CNT_W{1'b0}};
        end else begin
            font_r       <= FONT_ACT_LOW  ? ~i_font  : i_font;
            digit_r      <= DIGIT_ACT_LOW ? ~i_digit : i_digit;
            prev_font_r  <= font_r;
            prev_digit_r <= digit_r;
            if (!sel_valid_s || !same_s) begin
                stable_cnt_r <= {CNT_W{1'b0}};
            end else if (stable_cnt_r != CNT_MAX) begin
                stable_cnt_r <= stable_cnt_r + CNT_ONE;
            end else begin
                stable_cnt_r <= stable_cnt_r;
            end
        end
    end

    // Error pulse, saturating error count and stall watchdog.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            timeout_cnt_r <= {TO_W{1'b0}};
            o_stalled     <= 1'b0;
            o_err         <= 1'b0;
            o_err_cnt     <= 8'd0;
        end else begin
            timeout_cnt_r <= timeout_nxt_s;
            o_stalled     <= (timeout_nxt_s == TO_MAX);
            o_err         <= commit_s && dec_s[4];
            if (commit_s && dec_s[4] && (o_err_cnt != 8'hFF)) begin
                o_err_cnt <= o_err_cnt + 8'd1;
            end else begin
                o_err_cnt <= o_err_cnt;
            end
        end
    end

    // Frame assembly FSM; frame outputs load on the commit that completes coverage.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_r       <= S_WAIT;
            shadow_r      <= 16'd0;
            shadow_dp_r   <= 4'd0;
            mask_r        <= 4'd0;
            o_value       <= 16'd0;
            o_dp          <= 4'd0;
            o_frame_valid <= 1'b0;
        end else begin
            shadow_r      <= shadow_nxt_s;
            shadow_dp_r   <= shadow_dp_nxt_s;
            mask_r        <= mask_nxt_s;
            o_frame_valid <= 1'b0;
            case (state_r)
                S_WAIT: begin
                    if (commit_s && full_s) begin
                        state_r       <= S_EMIT;
                        o_value       <= shadow_nxt_s;
                        o_dp          <= shadow_dp_nxt_s;
                        o_frame_valid <= 1'b1;
                    end else if (commit_s) begin
                        state_r <= S_COLLECT;
                    end else begin
                        state_r <= S_WAIT;
                    end
                end
                S_COLLECT: begin
                    if (commit_s && full_s) begin
                        state_r       <= S_EMIT;
                        o_value       <= shadow_nxt_s;
                        o_dp          <= shadow_dp_nxt_s;
                        o_frame_valid <= 1'b1;
                    end else begin
                        state_r <= S_COLLECT;
                    end
                end
                S_EMIT:  state_r <= S_WAIT;
                default: state_r <= S_WAIT;
            endcase
        end
    end

endmodule
